uart_tx: RTL

- Serial UART transmitter that drains bytes from a valid/ready byte stream (normally the read side of the UART byte FIFO) and serializes them onto a single TX line.
- Frame: 8N1 or 8N2, LSB first, idle-high line.
- Sits between the TX byte FIFO and the device pin; one byte in flight at a time, no internal queueing.

---
 rtl/uart_tx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 / 8N2 serial transmitter fed by a valid/ready byte stream.
// Frame is LSB first on an idle-high line. txd is a flop that follows the
// FSM state one cycle later, so a byte accepted on edge T drives the start
// bit from edge T+1 onward and the frame ends exactly one idle cycle before
// the next possible start.
// Optional: define UART_TX_PARITY_EN to insert one even-parity bit between
// the data bits and the stop bit(s).
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             stop_cnt_reg;
    logic             txd_reg;
    logic             busy_reg;
    logic             ready_reg;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg;
`endif

    logic bit_end;
    logic last_stop;

    assign bit_end   = (baud_cnt_reg == CNT_LAST);
    // A second stop period is only needed when two stop bits are configured
    assign last_stop = (STOP_BITS == 1) || (stop_cnt_reg == 1'b1);

    assign s_ready = ready_reg;
    assign busy    = busy_reg;
    assign txd     = txd_reg;

    // Frame FSM: accepts a byte in IDLE, then times start/data/(parity)/stop
    // bit periods; txd, busy and s_ready are all registered here.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            stop_cnt_reg <= 1'b0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
            ready_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            // Line level is the previous cycle's state decode
            case (state_reg)
                ST_START:  txd_reg <= 1'b0;
                ST_DATA:   txd_reg <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
                ST_PARITY: txd_reg <= parity_reg;
`endif
                default:   txd_reg <= 1'b1;
            endcase

            case (state_reg)
                ST_IDLE: begin
                    if (s_valid && ready_reg) begin
                        state_reg    <= ST_START;
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        stop_cnt_reg <= 1'b0;
                        shift_reg    <= s_data;
                        busy_reg     <= 1'b1;
                        ready_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_reg   <= ^s_data;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg  <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= ST_STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (last_stop) begin
                            stop_cnt_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
                            busy_reg     <= 1'b0;
                            ready_reg    <= 1'b1;
                        end else begin
                            stop_cnt_reg <= 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule
